// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg : state encoding, access-size codes and request legality    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ACCESS   = 3'd1,
      RMW_READ = 3'd2,
      WRITE    = 3'd3,
      RESP     = 3'd4
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Illegal size code or a natural-alignment violation for the given size.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_align : little-endian lane extract/extend and store merge       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  offset,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   input  logic [31:0] merge_word,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rd_word[{offset, 3'b000} +: 8];
      half_sel   = offset[1] ? rd_word[31:16] : rd_word[15:0];
      load_data  = rd_word;
      store_word = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{~uns & byte_sel[7]}}, byte_sel};
            store_word = merge_word;
            store_word[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data  = {{16{~uns & half_sel[15]}}, half_sel};
            store_word = merge_word;
            store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            load_data  = rd_word;
            store_word = wdata;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit : single-outstanding core-to-data-memory LSU        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] store_word;

   lsu_align u_align (
      .size       (size_q),
      .uns        (uns_q),
      .offset     (addr_q[1:0]),
      .rd_word    (mem_rd),
      .wdata      (wdata_q),
      .merge_word (merge_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   assign req_ready  = (state_q == IDLE) & ~rst;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = (state_q == IDLE) ? '0 : {2'b00, addr_q[ADDR_W-1:2]};
   // Combinational gate so a reset landing in WRITE kills that cycle's write.
   assign mem_we     = (state_q == WRITE) & ~rst;
   assign mem_wd     = mem_we ? store_word : '0;

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      merge_d      = merge_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               we_d         = req_we;
               size_d       = req_size;
               uns_d        = req_unsigned;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               resp_rdata_d = '0;
               if (req_bad(req_size, req_addr[1:0])) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_we) begin
                  state_d = ACCESS;
               end else if (req_size == SZ_WORD) begin
                  state_d = WRITE;
               end else begin
                  state_d = RMW_READ;
               end
            end
         end
         ACCESS: begin
            resp_rdata_d = load_data;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RMW_READ: begin
            merge_d = mem_rd;
            state_d = WRITE;
         end
         WRITE: begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         merge_q      <= merge_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule
`default_nettype wire
